// File: rtl/cpu_load_sequencer.sv
// rtl/cpu_load_sequencer.sv - loads words into instruction memory, then sequences CPU reset, run and halt (optional LOAD_CHECKSUM_EN)
module cpu_load_sequencer #(
    parameter int ADDR_W      = 6,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              LoadInstructions,
    input  logic [31:0]       Instruction,
    input  logic [31:0]       cpu_pc,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              cpu_halt,
    output logic [ADDR_W:0]   instr_count,
    output logic              overflow,
    output logic [1:0]        state,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_HOLD = 2'b10,
        ST_RUN  = 2'b11
    } state_t;

    // Depth is one past the largest word address, so the count needs the extra bit.
    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]      HOLD_INIT = 4'(HOLD_CYCLES);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rst_q, rst_d;
    logic                halt_q, halt_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [3:0]          hold_q, hold_d;

    // A session start stores its word at address 0; an accept stores at the current count.
    logic                start;
    logic                accept;
    logic [ADDR_W-1:0]   pc_idx;
    logic                pc_past_end;
    logic                unused_pc;

    assign pc_idx      = cpu_pc[ADDR_W+1:2];
    assign pc_past_end = ({1'b0, pc_idx} >= count_q);
    assign unused_pc   = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rst_q   <= 1'b1;
            halt_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rst_q   <= rst_d;
            halt_q  <= halt_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic: session control, write generation, hold countdown and halt detect.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rst_d   = rst_q;
        halt_d  = halt_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        hold_d  = hold_q;
        start   = 1'b0;
        accept  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rst_d  = 1'b1;
                halt_d = 1'b0;
                start  = LoadInstructions;
            end
            ST_LOAD: begin
                if (LoadInstructions) begin
                    if (count_q < DEPTH) begin
                        accept = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (LoadInstructions) begin
                    start = 1'b1;
                end else if (hold_q <= 4'd1) begin
                    // Counter reaches zero on this edge: release the CPU.
                    hold_d  = '0;
                    state_d = ST_RUN;
                    rst_d   = 1'b0;
                    halt_d  = (count_q == '0);
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: begin
                if (LoadInstructions) begin
                    start = 1'b1;
                end else begin
                    rst_d = 1'b0;
                    if (pc_past_end) begin
                        halt_d = 1'b1;
                    end
                end
            end
        endcase

        if (start) begin
            state_d = ST_LOAD;
            rst_d   = 1'b1;
            halt_d  = 1'b0;
            ovf_d   = 1'b0;
            hold_d  = '0;
            we_d    = 1'b1;
            addr_d  = '0;
            wdata_d = Instruction;
            count_d = {{ADDR_W{1'b0}}, 1'b1};
        end else if (accept) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = Instruction;
            count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    assign checksum_d = start  ? Instruction :
                        accept ? (checksum_q ^ Instruction) :
                                 checksum_q;

    // Running XOR of the words stored in the current session.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_rst     = rst_q;
    assign cpu_halt    = halt_q;
    assign instr_count = count_q;
    assign overflow    = ovf_q;
    assign state       = state_q;

endmodule
